// File: rtl/parser_rule_cfg_arb_if.sv
// Rule-configuration bus bundle: requester handshake on one side, parser rule port on the other.
// slave = the arbiter, master = requesters plus parser environment.
interface parser_rule_cfg_arb_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [NUM_REQ-1:0]    i_req_wr;
  logic [NUM_REQ*32-1:0] i_req_addr;
  logic [NUM_REQ*32-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [NUM_REQ-1:0]    o_rsp_valid;
  logic [31:0]           o_rsp_rdata;
  logic                  o_rsp_err;
  logic                  o_rule_wren;
  logic                  o_rule_rden;
  logic [31:0]           o_rule_addr;
  logic [31:0]           o_rule_wdata;
  logic                  i_rule_rdata_valid;
  logic [31:0]           i_rule_rdata;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_addr, i_req_wdata,
    input  i_rule_rdata_valid, i_rule_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_addr, i_req_wdata,
    output i_rule_rdata_valid, i_rule_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata
  );
endinterface

// File: rtl/parser_rule_cfg_arb.sv
// Round-robin arbiter serialising NUM_REQ requesters onto the parser rule-config bus,
// with layer-ID validation, read timeout and one response pulse per accepted request.
module parser_rule_cfg_arb #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned LAYER_NUM  = 4,
  parameter int unsigned RD_TIMEOUT = 16,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  parser_rule_cfg_arb_if.slave bus
);
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = $clog2(RD_TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic          wr_q, wr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [GW-1:0] sel, cand;
  logic          any_req, sel_wr, bad_layer;
  logic [31:0]   sel_addr, sel_wdata;

  // Walk downwards so the closest requester after last_q is the final assignment.
  always_comb begin
    sel  = last_q;
    cand = '0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      cand = GW'((32'(last_q) + i) % NUM_REQ);
      if (bus.i_req_valid[cand]) sel = cand;
    end
  end

  always_comb begin
    any_req   = |bus.i_req_valid;
    sel_wr    = bus.i_req_wr[sel];
    sel_addr  = bus.i_req_addr[32*32'(sel) +: 32];
    sel_wdata = bus.i_req_wdata[32*32'(sel) +: 32];
    bad_layer = 32'(sel_addr[31:24]) >= LAYER_NUM;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d = sel;
          wr_d  = sel_wr;
          if (bad_layer) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
          end else begin
            // Rule-bus address/data only change on a legal accept, so they hold across errors.
            state_d = S_ISSUE;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
          end
        end
      end
      S_ISSUE: begin
        if (wr_q) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = '0;
        end else begin
          state_d = S_WAIT_RD;
          timer_d = '0;
        end
      end
      S_WAIT_RD: begin
        timer_d = timer_q + TW'(1);
        if (bus.i_rule_rdata_valid) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = bus.i_rule_rdata;
        end else if (timer_q == TW'(RD_TIMEOUT - 1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
        end
      end
      default: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      last_q  <= GW'(NUM_REQ - 1);
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      timer_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Ready is combinational, so it is masked while reset is asserted.
  assign bus.o_req_ready  = (i_rst_n && state_q == S_IDLE && any_req) ? (NUM_REQ'(1) << sel) : '0;
  assign bus.o_rsp_valid  = (state_q == S_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign bus.o_rsp_rdata  = rdata_q;
  assign bus.o_rsp_err    = err_q;
  assign bus.o_rule_wren  = (state_q == S_ISSUE) && wr_q;
  assign bus.o_rule_rden  = (state_q == S_ISSUE) && !wr_q;
  assign bus.o_rule_addr  = addr_q;
  assign bus.o_rule_wdata = wdata_q;
endmodule
